// File: rtl/sfq_toggle_decoder.sv
// rtl/sfq_toggle_decoder.sv - recovers bits from toggle-encoded SFQ clock/data streams, packs words, flags violations
module sfq_toggle_decoder #(
    parameter int SYNC_STAGES = 2,
    parameter int HOLD_CYC    = 3,
    parameter int WORD_W      = 8,
    parameter int CNT_W       = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              sfq_clk,
    input  logic              sfq_data,
    input  logic              clr_cnt,
    output logic              bit_valid,
    output logic              bit_data,
    output logic              word_valid,
    output logic [WORD_W-1:0] word_data,
    output logic              word_err,
    output logic              err_timing,
    output logic              err_double,
    output logic [CNT_W-1:0]  timing_cnt,
    output logic [CNT_W-1:0]  double_cnt,
    output logic [CNT_W-1:0]  bit_cnt
);

    localparam int TMR_W = (HOLD_CYC > 0) ? $clog2(HOLD_CYC + 1) : 1;
    localparam int IDX_W = (WORD_W > 1) ? $clog2(WORD_W) : 1;

    typedef enum logic [1:0] {S_INIT, S_EMPTY, S_FULL} state_t;

    logic [SYNC_STAGES-1:0] clk_sync, data_sync;
    logic                   clk_prev, data_prev;
    logic                   clk_ev, data_ev;

    state_t           state, state_nxt;
    logic [TMR_W-1:0] timer, timer_nxt, timer_eff;
    logic             emit, emit_val, terr, derr;

    logic [IDX_W-1:0]  idx;
    logic [WORD_W-1:0] shadow, shadow_nxt;
    logic              err_acc, word_last;

    // Each toggle on either wire is one pulse; history flop turns edges into 1-cycle events
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            clk_sync  <= '0;
            data_sync <= '0;
            clk_prev  <= 1'b0;
            data_prev <= 1'b0;
        end else begin
            clk_sync  <= {clk_sync[SYNC_STAGES-2:0], sfq_clk};
            data_sync <= {data_sync[SYNC_STAGES-2:0], sfq_data};
            clk_prev  <= clk_sync[SYNC_STAGES-1];
            data_prev <= data_sync[SYNC_STAGES-1];
        end
    end

    assign clk_ev  = clk_sync[SYNC_STAGES-1] ^ clk_prev;
    assign data_ev = data_sync[SYNC_STAGES-1] ^ data_prev;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_INIT;
            timer <= '0;
        end else begin
            state <= state_nxt;
            timer <= timer_nxt;
        end
    end

    // Clock event is resolved first so a coincident data pulse lands in the new period
    always_comb begin
        state_nxt = state;
        timer_eff = timer;
        timer_nxt = (timer != '0) ? timer - 1'b1 : timer;
        emit      = 1'b0;
        emit_val  = 1'b0;
        terr      = 1'b0;
        derr      = 1'b0;
        if (clk_ev) begin
            emit      = (state != S_INIT);
            emit_val  = (state == S_FULL);
            state_nxt = S_EMPTY;
            timer_eff = TMR_W'(HOLD_CYC);
            timer_nxt = TMR_W'(HOLD_CYC);
        end
        if (data_ev) begin
            case (state_nxt)
                S_EMPTY: begin
                    state_nxt = S_FULL;
                    terr      = (timer_eff != '0);
                end
                S_FULL: begin
                    derr = 1'b1;
                    terr = (timer_eff != '0);
                end
                default: ;
            endcase
        end
    end

    assign word_last = (idx == IDX_W'(WORD_W - 1));

    always_comb begin
        shadow_nxt      = shadow;
        shadow_nxt[idx] = emit_val;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bit_valid  <= 1'b0;
            bit_data   <= 1'b0;
            err_timing <= 1'b0;
            err_double <= 1'b0;
            word_valid <= 1'b0;
            word_data  <= '0;
            word_err   <= 1'b0;
            idx        <= '0;
            shadow     <= '0;
            err_acc    <= 1'b0;
        end else begin
            bit_valid  <= emit;
            bit_data   <= emit_val;
            err_timing <= terr;
            err_double <= derr;
            word_valid <= 1'b0;
            word_err   <= 1'b0;
            // Errors strobing alongside word_valid belong to the following word
            if (emit && word_last) begin
                err_acc <= terr | derr;
            end else begin
                err_acc <= err_acc | terr | derr;
            end
            if (emit) begin
                shadow <= shadow_nxt;
                if (word_last) begin
                    idx        <= '0;
                    word_data  <= shadow_nxt;
                    word_valid <= 1'b1;
                    word_err   <= err_acc;
                end else begin
                    idx <= idx + 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            timing_cnt <= '0;
            double_cnt <= '0;
            bit_cnt    <= '0;
        end else if (clr_cnt) begin
            timing_cnt <= '0;
            double_cnt <= '0;
            bit_cnt    <= '0;
        end else begin
            if (terr && (timing_cnt != '1)) timing_cnt <= timing_cnt + 1'b1;
            if (derr && (double_cnt != '1)) double_cnt <= double_cnt + 1'b1;
            if (emit && (bit_cnt != '1))    bit_cnt    <= bit_cnt + 1'b1;
        end
    end

endmodule

// File: tb/tb_sfq_toggle_decoder.sv
// tb/tb_sfq_toggle_decoder.sv - directed scoreboard bench for sfq_toggle_decoder
module tb_sfq_toggle_decoder;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        sfq_clk, sfq_data, clr_cnt;
    logic        bit_valid, bit_data, word_valid, word_err, err_timing, err_double;
    logic [7:0]  word_data;
    logic [15:0] timing_cnt, double_cnt, bit_cnt;

    int checks = 0;
    int errors = 0;

    bit         exp_bits[$];
    logic [8:0] exp_words[$];

    bit         m_init, m_full, m_err;
    int         m_idx;
    logic [7:0] m_word;
    int         m_tcnt, m_dcnt, m_bcnt, exp_timing, exp_double;

    int         seen_timing = 0;
    int         seen_double = 0;
    int         words_seen  = 0;
    logic [7:0] last_word;
    logic       last_word_err;

    sfq_toggle_decoder dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .sfq_clk    (sfq_clk),
        .sfq_data   (sfq_data),
        .clr_cnt    (clr_cnt),
        .bit_valid  (bit_valid),
        .bit_data   (bit_data),
        .word_valid (word_valid),
        .word_data  (word_data),
        .word_err   (word_err),
        .err_timing (err_timing),
        .err_double (err_double),
        .timing_cnt (timing_cnt),
        .double_cnt (double_cnt),
        .bit_cnt    (bit_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic int sat(input int v);
        return (v >= 65535) ? 65535 : v + 1;
    endfunction

    task automatic model_reset();
        m_init = 0; m_full = 0; m_err = 0; m_idx = 0; m_word = '0;
        m_tcnt = 0; m_dcnt = 0; m_bcnt = 0;
    endtask

    task automatic model_clock();
        if (m_init) begin
            exp_bits.push_back(m_full);
            m_word[m_idx] = m_full;
            m_bcnt = sat(m_bcnt);
            if (m_idx == 7) begin
                exp_words.push_back({m_err, m_word});
                m_idx = 0;
                m_err = 0;
            end else begin
                m_idx++;
            end
        end
        m_init = 1;
        m_full = 0;
    endtask

    task automatic model_data(input bit timing_violation);
        if (m_init) begin
            if (m_full) begin
                exp_double++;
                m_dcnt = sat(m_dcnt);
                m_err  = 1;
            end
            if (timing_violation) begin
                exp_timing++;
                m_tcnt = sat(m_tcnt);
                m_err  = 1;
            end
            m_full = 1;
        end
    endtask

    task automatic wait_cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic do_clock();
        sfq_clk = ~sfq_clk;
        model_clock();
    endtask

    task automatic do_data(input bit timing_violation);
        sfq_data = ~sfq_data;
        model_data(timing_violation);
    endtask

    task automatic do_both();
        sfq_clk  = ~sfq_clk;
        sfq_data = ~sfq_data;
        model_clock();
        model_data(1'b1);
    endtask

    task automatic finish_word();
        while (m_idx != 0) begin
            wait_cyc(20);
            do_clock();
        end
        wait_cyc(8);
    endtask

    task automatic check_counters(input string tag);
        chk({tag, "_timing_cnt"}, timing_cnt, m_tcnt);
        chk({tag, "_double_cnt"}, double_cnt, m_dcnt);
        chk({tag, "_bit_cnt"}, bit_cnt, m_bcnt);
    endtask

    always @(negedge clk) begin
        if (rst_n) begin
            if (bit_valid) begin
                if (exp_bits.size() == 0) chk("bit_unexpected", bit_valid, 0);
                else chk("bit_data", bit_data, exp_bits.pop_front());
            end
            if (word_valid) begin
                if (exp_words.size() == 0) begin
                    chk("word_unexpected", word_valid, 0);
                end else begin
                    logic [8:0] ew;
                    ew = exp_words.pop_front();
                    chk("word_data", word_data, ew[7:0]);
                    chk("word_err", word_err, ew[8]);
                end
                last_word     = word_data;
                last_word_err = word_err;
                words_seen++;
            end
            if (err_timing) seen_timing++;
            if (err_double) seen_double++;
        end
    end

    initial begin
        logic [7:0] pattern;
        rst_n = 1'b0; sfq_clk = 1'b0; sfq_data = 1'b0; clr_cnt = 1'b0;
        exp_timing = 0; exp_double = 0;
        model_reset();
        wait_cyc(3);
        chk("rst_bit_valid", bit_valid, 0);
        chk("rst_word_valid", word_valid, 0);
        chk("rst_word_data", word_data, 0);
        chk("rst_err", {err_timing, err_double, word_err}, 0);
        check_counters("rst");
        rst_n = 1'b1;
        wait_cyc(3);

        // 1: alternating data; first clock opens the stream without a bit
        for (int i = 1; i <= 9; i++) begin
            do_clock();
            wait_cyc(10);
            if (i % 2 == 1 && i <= 7) do_data(1'b0);
            wait_cyc(10);
        end
        wait_cyc(6);
        chk("t1_word_data", word_data, 8'h55);
        chk("t1_words_seen", words_seen, 1);
        chk("t1_word_err", last_word_err, 0);
        check_counters("t1");

        // 2: data one cycle after the clock is inside the hold window
        do_clock();
        wait_cyc(1);
        do_data(1'b1);
        wait_cyc(19);
        do_clock();
        wait_cyc(6);
        chk("t2_seen_timing", seen_timing, 1);
        check_counters("t2");

        // 3: two data pulses in one period
        wait_cyc(10);
        do_data(1'b0);
        wait_cyc(5);
        do_data(1'b0);
        wait_cyc(5);
        do_clock();
        wait_cyc(6);
        chk("t3_seen_double", seen_double, 1);
        check_counters("t3");

        // 4: empty period, then clock and data on the same edge
        wait_cyc(14);
        do_clock();
        wait_cyc(20);
        do_both();
        wait_cyc(20);
        do_clock();
        finish_word();
        chk("t4_seen_timing", seen_timing, 2);
        chk("t4_words_seen", words_seen, 2);
        chk("t4_word_err", last_word_err, 1);
        check_counters("t4");

        // 5: saturate timing_cnt, one more violation, then a clear colliding with a violation
        wait_cyc(20);
        repeat (65535) begin
            do_both();
            wait_cyc(1);
        end
        wait_cyc(8);
        chk("t5_timing_sat", timing_cnt, 16'hFFFF);
        do_clock();
        wait_cyc(1);
        do_data(1'b1);
        wait_cyc(8);
        chk("t5_timing_hold", timing_cnt, 16'hFFFF);
        chk("t5_seen_timing", seen_timing, exp_timing);
        wait_cyc(10);
        do_both();
        wait_cyc(2);
        clr_cnt = 1'b1;
        wait_cyc(1);
        clr_cnt = 1'b0;
        m_tcnt = 0; m_dcnt = 0; m_bcnt = 0;
        wait_cyc(6);
        check_counters("t5_clr");
        chk("t5_seen_timing_clr", seen_timing, exp_timing);

        // 6: asynchronous reset mid-word
        finish_word();
        for (int i = 0; i < 5; i++) begin
            wait_cyc(10);
            do_clock();
            wait_cyc(10);
            if (i % 2 == 0) do_data(1'b0);
        end
        wait_cyc(8);
        chk("t6_idx_model", m_idx, 5);
        #2;
        rst_n = 1'b0;
        #1;
        chk("t6_async_bit_cnt", bit_cnt, 0);
        chk("t6_async_word_data", word_data, 0);
        chk("t6_async_strobes", {bit_valid, bit_data, word_valid, word_err, err_timing, err_double}, 0);
        chk("t6_async_err_cnts", {timing_cnt, double_cnt}, 0);
        sfq_clk = 1'b0;
        sfq_data = 1'b0;
        model_reset();
        wait_cyc(3);
        rst_n = 1'b1;
        wait_cyc(5);
        pattern = 8'b1100_1011;
        do_clock();
        for (int i = 0; i < 8; i++) begin
            wait_cyc(10);
            if (pattern[i]) do_data(1'b0);
            wait_cyc(10);
            do_clock();
        end
        wait_cyc(8);
        chk("t6_word_data", last_word, pattern);
        check_counters("t6");

        chk("end_bits_pending", exp_bits.size(), 0);
        chk("end_words_pending", exp_words.size(), 0);
        chk("end_seen_timing", seen_timing, exp_timing);
        chk("end_seen_double", seen_double, exp_double);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
